// File: rtl/i2s_clk_gen_pkg.sv
// i2s_pkg: shared types for the I2S/TDM clock generator.
//   i2s_state_e   - generator FSM states (IDLE, RUN, DRAIN)
//   i2s_ws_mode_e - word-select style (WS_I2S = 50% duty, WS_PULSE = one-bclk frame sync)
//   idx_w()       - index width helper, max(1, $clog2(n))
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_e;

  typedef enum logic {
    WS_I2S   = 1'b0,
    WS_PULSE = 1'b1
  } i2s_ws_mode_e;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_gen_if.sv
// i2s_clk_gen_if: configuration and clock/strobe bundle of the I2S/TDM clock generator.
//   master: drives enable, div_half, ws_mode; observes the generated clocks
//   slave : the generator itself
//   enable, div_half, ws_mode           - run request and configuration
//   bclk, ws                            - registered clock levels
//   bclk_rise, bclk_fall, frame_start   - single-cycle strobes
//   slot_idx, bit_idx, running          - position within frame, activity flag
interface i2s_clk_gen_if #(
  parameter int DIV_W     = 8,
  parameter int SLOT_BITS = 24,
  parameter int NUM_SLOTS = 2
);
  localparam int SLOT_W = i2s_pkg::idx_w(NUM_SLOTS);
  localparam int BIT_W  = i2s_pkg::idx_w(SLOT_BITS);

  logic              enable;
  logic [DIV_W-1:0]  div_half;
  logic              ws_mode;
  logic              bclk;
  logic              ws;
  logic              bclk_rise;
  logic              bclk_fall;
  logic              frame_start;
  logic [SLOT_W-1:0] slot_idx;
  logic [BIT_W-1:0]  bit_idx;
  logic              running;

  modport master (
    output enable, div_half, ws_mode,
    input  bclk, ws, bclk_rise, bclk_fall, frame_start, slot_idx, bit_idx, running
  );

  modport slave (
    input  enable, div_half, ws_mode,
    output bclk, ws, bclk_rise, bclk_fall, frame_start, slot_idx, bit_idx, running
  );

endinterface

// File: rtl/i2s_half_div.sv
// i2s_half_div: half-bclk-period counter.
//   clk_ref - reference clock
//   rst     - synchronous active-high reset
//   run     - count enable; counter is held at 0 while low
//   div_q   - half period minus one, in clk_ref cycles
//   tick    - high in the last cycle of each half period (bclk toggles on the next edge)
module i2s_half_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div_q,
  output logic             tick
);

  logic [DIV_W-1:0] hcnt;

  assign tick = run && (hcnt == div_q);

  // Holding at 0 while stopped means the first half period after start is full length.
  always_ff @(posedge clk_ref) begin
    if (rst || !run || tick) hcnt <= '0;
    else                     hcnt <= hcnt + DIV_W'(1);
  end

endmodule

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: parametrised I2S/TDM bit- and frame-clock generator.
//   clk_ref - reference clock, all logic on its rising edge
//   rst     - synchronous active-high reset
//   bus     - i2s_clk_gen_if slave: enable/div_half/ws_mode in;
//             bclk, ws, bclk_rise, bclk_fall, frame_start, slot_idx, bit_idx, running out
// All outputs are registered. Configuration is sampled only at start and at frame wrap.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int SLOT_BITS = 24,
  parameter int NUM_SLOTS = 2
) (
  input logic          clk_ref,
  input logic          rst,
  i2s_clk_gen_if.slave bus
);

  localparam int SLOT_W = idx_w(NUM_SLOTS);
  localparam int BIT_W  = idx_w(SLOT_BITS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] HALF_SLOT = SLOT_W'(NUM_SLOTS / 2);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);

  i2s_state_e        state_q, state_d;
  i2s_ws_mode_e      mode_q, mode_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              bclk_q, bclk_d;
  logic              ws_q, ws_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              fs_q, fs_d;
  logic              run_q, run_d;
  logic [SLOT_W-1:0] slot_q, slot_d, slot_nx;
  logic [BIT_W-1:0]  bit_q, bit_d, bit_nx;
  logic              wrap;
  logic              tick;
  logic              div_run;

  function automatic logic ws_level(input i2s_ws_mode_e m, input logic [SLOT_W-1:0] s,
                                    input logic [BIT_W-1:0] b);
    if (m == WS_PULSE) return (s == '0) && (b == '0);
    return s >= HALF_SLOT;
  endfunction

  assign div_run = (state_q != IDLE);

  i2s_half_div #(.DIV_W(DIV_W)) u_half_div (
    .clk_ref (clk_ref),
    .rst     (rst),
    .run     (div_run),
    .div_q   (div_q),
    .tick    (tick)
  );

  // Position after the next bclk falling edge; wrap flags the end of the frame.
  always_comb begin
    bit_nx  = bit_q;
    slot_nx = slot_q;
    wrap    = 1'b0;
    if (bit_q == LAST_BIT) begin
      bit_nx = '0;
      if (slot_q == LAST_SLOT) begin
        slot_nx = '0;
        wrap    = 1'b1;
      end else begin
        slot_nx = slot_q + SLOT_W'(1);
      end
    end else begin
      bit_nx = bit_q + BIT_W'(1);
    end
  end

  // A stop request is honoured only at frame wrap, so enable low at the wrap edge
  // ends generation whether the FSM had already moved to DRAIN or not.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    bclk_d  = bclk_q;
    ws_d    = ws_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    fs_d    = 1'b0;
    slot_d  = slot_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = RUN;
          div_d   = bus.div_half;
          mode_d  = i2s_ws_mode_e'(bus.ws_mode);
          fs_d    = 1'b1;
          slot_d  = '0;
          bit_d   = '0;
          ws_d    = ws_level(i2s_ws_mode_e'(bus.ws_mode), '0, '0);
        end
      end
      RUN, DRAIN: begin
        state_d = bus.enable ? RUN : DRAIN;
        if (tick) begin
          if (!bclk_q) begin
            bclk_d = 1'b1;
            rise_d = 1'b1;
          end else begin
            bclk_d = 1'b0;
            fall_d = 1'b1;
            slot_d = slot_nx;
            bit_d  = bit_nx;
            if (wrap && !bus.enable) begin
              state_d = IDLE;
              ws_d    = 1'b0;
            end else if (wrap) begin
              fs_d   = 1'b1;
              div_d  = bus.div_half;
              mode_d = i2s_ws_mode_e'(bus.ws_mode);
              ws_d   = ws_level(i2s_ws_mode_e'(bus.ws_mode), slot_nx, bit_nx);
            end else begin
              ws_d = ws_level(mode_q, slot_nx, bit_nx);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= WS_I2S;
      div_q   <= '0;
      bclk_q  <= 1'b0;
      ws_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      fs_q    <= 1'b0;
      run_q   <= 1'b0;
      slot_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      ws_q    <= ws_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      fs_q    <= fs_d;
      run_q   <= run_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
    end
  end

  assign bus.bclk        = bclk_q;
  assign bus.ws          = ws_q;
  assign bus.bclk_rise   = rise_q;
  assign bus.bclk_fall   = fall_q;
  assign bus.frame_start = fs_q;
  assign bus.slot_idx    = slot_q;
  assign bus.bit_idx     = bit_q;
  assign bus.running     = run_q;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// tb_i2s_clk_gen: directed bench for i2s_clk_gen.
// Two instances share stimulus: dut_a uses defaults (24 bits x 2 slots),
// dut_b is TDM (16 bits x 8 slots); sel chooses which one is observed.
module tb_i2s_clk_gen;

  logic       clk_ref = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] div_half;
  logic       ws_mode;

  int sel;
  int tcnt;
  int n_checks;
  int n_fail;

  logic o_bclk, o_ws, o_rise, o_fall, o_fs, o_running;
  int   o_slot, o_bit;

  i2s_clk_gen_if #(.DIV_W(8), .SLOT_BITS(24), .NUM_SLOTS(2)) bus_a ();
  i2s_clk_gen_if #(.DIV_W(8), .SLOT_BITS(16), .NUM_SLOTS(8)) bus_b ();

  assign bus_a.enable   = enable;
  assign bus_a.div_half = div_half;
  assign bus_a.ws_mode  = ws_mode;
  assign bus_b.enable   = enable;
  assign bus_b.div_half = div_half;
  assign bus_b.ws_mode  = ws_mode;

  i2s_clk_gen #(.DIV_W(8), .SLOT_BITS(24), .NUM_SLOTS(2)) dut_a (
    .clk_ref (clk_ref),
    .rst     (rst),
    .bus     (bus_a)
  );

  i2s_clk_gen #(.DIV_W(8), .SLOT_BITS(16), .NUM_SLOTS(8)) dut_b (
    .clk_ref (clk_ref),
    .rst     (rst),
    .bus     (bus_b)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    int sel;
    int div;
    int mode;
    int exp_lat;
    int exp_period;
    int exp_frame;
    int exp_ws_high;
    int exp_falls;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk_ref);
    #1;
    tcnt++;
    if (sel == 0) begin
      o_bclk = bus_a.bclk; o_ws = bus_a.ws; o_rise = bus_a.bclk_rise; o_fall = bus_a.bclk_fall;
      o_fs = bus_a.frame_start; o_running = bus_a.running;
      o_slot = int'(bus_a.slot_idx); o_bit = int'(bus_a.bit_idx);
    end else begin
      o_bclk = bus_b.bclk; o_ws = bus_b.ws; o_rise = bus_b.bclk_rise; o_fall = bus_b.bclk_fall;
      o_fs = bus_b.frame_start; o_running = bus_b.running;
      o_slot = int'(bus_b.slot_idx); o_bit = int'(bus_b.bit_idx);
    end
  endtask

  task automatic check_output(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reset, check the all-zero state, then start with the given config; returns in the
  // first running cycle with tcnt = 0.
  task automatic apply_stimulus(input string tag, input int d, input int m);
    rst = 1'b1;
    enable = 1'b0;
    step();
    check_output({tag, "_reset_outputs"},
                 int'({o_bclk, o_ws, o_rise, o_fall, o_fs, o_running}) + o_slot + o_bit, 0);
    rst = 1'b0;
    div_half = 8'(d);
    ws_mode = m[0];
    enable = 1'b1;
    step();
    tcnt = 0;
  endtask

  task automatic run_vector(input int i, input vec_t v);
    int first_rise, second_rise, frame_len, ws_cnt, falls, rises, ws_bad, limit, nslots;
    logic exp_ws;
    string tag;
    tag = $sformatf("v%0d", i);
    sel = v.sel;
    nslots = (v.sel == 0) ? 2 : 8;
    apply_stimulus(tag, v.div, v.mode);
    check_output({tag, "_start_fs"}, int'(o_fs), 1);
    check_output({tag, "_start_running"}, int'(o_running), 1);
    check_output({tag, "_start_ws"}, int'(o_ws), v.mode);
    first_rise = -1; second_rise = -1; frame_len = -1;
    ws_cnt = int'(o_ws); falls = 0; rises = 0; ws_bad = 0;
    limit = 3 * v.exp_frame;
    while (frame_len < 0 && tcnt < limit) begin
      step();
      if (o_fall) falls++;
      if (o_rise) begin
        rises++;
        if (first_rise < 0) first_rise = tcnt;
        else if (second_rise < 0) second_rise = tcnt;
      end
      if (o_fs) frame_len = tcnt;
      else ws_cnt += int'(o_ws);
      if (v.mode == 1) exp_ws = (o_slot == 0) && (o_bit == 0);
      else exp_ws = (o_slot >= nslots / 2);
      if (o_ws != exp_ws) ws_bad++;
    end
    check_output({tag, "_timeout"}, int'(frame_len < 0), 0);
    check_output({tag, "_frame_len"}, frame_len, v.exp_frame);
    check_output({tag, "_first_rise"}, first_rise, v.exp_lat);
    check_output({tag, "_bclk_period"}, second_rise - first_rise, v.exp_period);
    check_output({tag, "_ws_high"}, ws_cnt, v.exp_ws_high);
    check_output({tag, "_falls"}, falls, v.exp_falls);
    check_output({tag, "_rises"}, rises, v.exp_falls);
    check_output({tag, "_ws_vs_slot"}, ws_bad, 0);
  endtask

  initial begin
    int prev_rise, bad_iv, fs_t, r1, r2, drops;
    n_checks = 0; n_fail = 0; sel = 0; tcnt = 0;
    rst = 1'b1; enable = 1'b0; div_half = '0; ws_mode = 1'b0;

    //            sel div mode lat period frame ws_high falls
    vecs[0] = '{0, 23, 0, 24, 48, 2304, 1152,  48};
    vecs[1] = '{0,  0, 0,  1,  2,   96,   48,  48};
    vecs[2] = '{0,  5, 1,  6, 12,  576,   12,  48};
    vecs[3] = '{1,  3, 1,  4,  8, 1024,    8, 128};
    vecs[4] = '{1,  0, 0,  1,  2,  256,  128, 128};

    for (int i = 0; i < 5; i++) run_vector(i, vecs[i]);

    // Divider change mid-frame: takes effect only from the next frame_start.
    sel = 0;
    apply_stimulus("divchg", 23, 0);
    prev_rise = -1; bad_iv = 0; fs_t = -1; r1 = -1; r2 = -1;
    while (r2 < 0 && tcnt < 3000) begin
      step();
      if (tcnt == 100) div_half = 8'd11;
      if (o_fs && fs_t < 0) fs_t = tcnt;
      if (o_rise) begin
        if (fs_t < 0) begin
          if (prev_rise >= 0 && tcnt - prev_rise != 48) bad_iv++;
          prev_rise = tcnt;
        end else if (r1 < 0) r1 = tcnt;
        else r2 = tcnt;
      end
    end
    check_output("divchg_timeout", int'(r2 < 0), 0);
    check_output("divchg_old_period_errs", bad_iv, 0);
    check_output("divchg_frame_len", fs_t, 2304);
    check_output("divchg_new_first_rise", r1 - fs_t, 12);
    check_output("divchg_new_period", r2 - r1, 24);

    // Drop enable at slot 0 bit 5: frame completes, then IDLE with clean outputs.
    apply_stimulus("drain", 0, 0);
    while (!(o_slot == 0 && o_bit == 5) && tcnt < 200) step();
    check_output("drain_bit5_time", tcnt, 10);
    enable = 1'b0;
    fs_t = -1;
    while (o_running && tcnt < 300) begin
      step();
      if (o_fs) fs_t = tcnt;
    end
    check_output("drain_idle_time", tcnt, 96);
    check_output("drain_no_fs", fs_t, -1);
    check_output("drain_bclk", int'(o_bclk), 0);
    check_output("drain_ws", int'(o_ws), 0);
    check_output("drain_fall", int'(o_fall), 1);
    check_output("drain_indices", o_slot + o_bit, 0);
    step();
    check_output("drain_stays_idle", int'(o_running) + int'(o_fs), 0);

    // Re-assert enable while draining: frames continue without a gap.
    apply_stimulus("resume", 0, 0);
    while (!(o_slot == 0 && o_bit == 5) && tcnt < 200) step();
    enable = 1'b0;
    step(); step(); step();
    enable = 1'b1;
    drops = 0; r1 = -1; r2 = -1;
    while (r2 < 0 && tcnt < 400) begin
      step();
      if (!o_running) drops++;
      if (o_fs) begin
        if (r1 < 0) r1 = tcnt;
        else r2 = tcnt;
      end
    end
    check_output("resume_drops", drops, 0);
    check_output("resume_fs1", r1, 96);
    check_output("resume_fs2", r2, 192);

    // Reset mid-slot 1 with bclk high.
    apply_stimulus("rst", 23, 0);
    while (!(o_slot == 1 && o_bclk) && tcnt < 5000) step();
    check_output("rst_reach_slot1", int'(o_slot == 1 && o_bclk), 1);
    rst = 1'b1;
    enable = 1'b0;
    step();
    check_output("rst_bclk", int'(o_bclk), 0);
    check_output("rst_ws", int'(o_ws), 0);
    check_output("rst_strobes", int'({o_rise, o_fall, o_fs}), 0);
    check_output("rst_slot", o_slot, 0);
    check_output("rst_bit", o_bit, 0);
    check_output("rst_running", int'(o_running), 0);
    rst = 1'b0;
    step();
    check_output("rst_stays_idle", int'({o_running, o_bclk, o_fs}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
